nyq_sample_serializer: RTL
==========================

# nyq_sample_serializer

Downstream stage of the Nyquist decimation filter. Captures each decimated 24-bit sample on the filter's valid strobe, buffers it in a small FIFO, and shifts it off-chip MSB-first on a framed serial link (bit clock, data, frame sync). It runs in the same Clk_CI domain as the filter and is configured through the standard block parameter-write interface.

## Interface
- ADDR_WIDTH, 11, parameter address width (common to all blocks)
- MEM_WIDTH, 24, parameter word width (common to all blocks)
- IN_WIDTH, 24, sample width and bits per serial frame
- FIFO_DEPTH, 4, sample buffer entries (power of 2, ≥2)

- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- WrEn_SI  in  1  parameter write enable, active high
- Addr_DI  in  ADDR_WIDTH  parameter address
- PAR_In_DI  in  MEM_WIDTH  parameter write data
- SER_In_DI  in  IN_WIDTH  signed sample from the Nyquist filter output
- SER_Valid_SI  in  1  filter valid (level; may be high for ≥1 cycle per sample)
- SER_Sclk_DO  out  1  serial bit clock
- SER_Data_DO  out  1  serial data, MSB first
- SER_Frame_DO  out  1  frame sync, high for the whole MSB bit period
- SER_Busy_DO  out  1  high while a word is being shifted
- SER_Ovf_DO  out  1  sticky FIFO overflow flag
- SER_Level_DO  out  log2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Config registers (written when WrEn_SI=1; other addresses ignored):
  - addr 0 bit0: EN (reset 0)
  - addr 1 bits[7:0]: DIV, Clk_CI cycles per Sclk half-period (reset 1; written value 0 stored as 1)
  - addr 2: any write clears SER_Ovf_DO
- Capture: rising-edge detect on SER_Valid_SI (high now, low in the previous cycle). Each detected edge pushes SER_In_DI once, regardless of EN. A valid level held for N cycles gives one push.
- Push is accepted if Level<FIFO_DEPTH, or if Level==FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the sample is dropped and Ovf is set. If an addr-2 write and a new overflow occur in the same cycle, Ovf stays set.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if EN and FIFO not empty → pop head into the shift register, bit index = IN_WIDTH-1, → SHIFT.
  - SHIFT: each bit lasts 2·DIV cycles. Sclk is 0 for the first DIV cycles and 1 for the second DIV cycles. Data is the current shift-register MSB and changes only at the start of a bit. Frame=1 during bit IN_WIDTH-1. After bit 0 → GAP.
  - GAP: 2·DIV cycles with Sclk=0, Data=0, Frame=0, then → IDLE.
- DIV is sampled at the IDLE→SHIFT transition and held constant for the whole word.
- Clearing EN mid-word: the current word and its GAP complete, then the FSM stays in IDLE. The FIFO keeps filling.
- Busy=1 in SHIFT and GAP.

## Timing
- Reset values: Sclk, Data, Frame, Busy, Ovf = 0; Level = 0; FSM = IDLE; EN = 0; DIV = 1. Asserting reset mid-word aborts the word immediately and empties the FIFO.
- Push latency: valid edge sampled at clock edge k → Level increments after edge k.
- Start latency: FIFO becomes non-empty at edge k → pop at edge k+1, when Busy=1, Frame=1, Data=MSB and Sclk=0.
- Frame period = (IN_WIDTH+1)·2·DIV cycles, i.e. 50 cycles for DIV=1. This must not exceed the input sample period (256 cycles at OSR 256), otherwise the FIFO overflows.
- Back-to-back words: exactly one IDLE cycle between the end of GAP and the next pop.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, EN=1, DIV=1, valid edge with SER_In_DI=0xA5C381 → Frame high for cycles 2–3 after the edge; 24 bits 1010_0101_1100_0011_1000_0001 MSB first, each bit = 2 cycles with Sclk 0 then 1; then a 2-cycle gap; Busy falls 50 cycles after the pop.
- Valid held high 5 cycles with sample 0x000001 → exactly one word is sent and Level peaks at 1.
- EN=0, 5 valid edges with samples 1..5 → Level reaches 4 and Ovf=1 (sample 5 dropped). Then EN=1 → words 1,2,3,4 are sent in order. A write to addr 2 clears Ovf.
- DIV=3, sample 0x800000 → each Sclk half-period is 3 cycles and the frame is 150 cycles. A write of DIV=5 mid-word does not change the current word; the next word uses 5.
- Clear EN during bit 10 → the word and its gap finish, no further pop. Rst_RBI low mid-word → all outputs 0 and Level=0 immediately.
- Full FIFO with a pop and a valid edge in the same cycle → the push is accepted, Level stays 4 and Ovf stays 0.

Source files
------------

// File: rtl/nyq_sample_serializer.sv
// Serializes decimated Nyquist-filter samples through a small FIFO onto a
// framed MSB-first serial link (bit clock, data, frame sync).
module nyq_sample_serializer #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned MEM_WIDTH  = 24,
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RBI,
  input  logic                          WrEn_SI,
  input  logic [ADDR_WIDTH-1:0]         Addr_DI,
  input  logic [MEM_WIDTH-1:0]          PAR_In_DI,
  input  logic [IN_WIDTH-1:0]           SER_In_DI,
  input  logic                          SER_Valid_SI,
  output logic                          SER_Sclk_DO,
  output logic                          SER_Data_DO,
  output logic                          SER_Frame_DO,
  output logic                          SER_Busy_DO,
  output logic                          SER_Ovf_DO,
  output logic [$clog2(FIFO_DEPTH):0]   SER_Level_DO
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned BW = $clog2(IN_WIDTH);
  localparam int unsigned DW = 8;
  localparam int unsigned CW = DW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e                state_q, state_d;
  logic                  en_q, ovf_q, valid_q;
  logic [DW-1:0]         div_q, wdiv_q, wdiv_d;
  logic [IN_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [IN_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sclk_q, data_q, frame_q, busy_q;
  logic                  sclk_d, data_d, frame_d, busy_d;
  logic                  push_c, push_ok_c, pop_c, cnt_last_c;
  logic                  wr_en_c, wr_div_c, wr_clr_c;
  logic                  unused_par_c;

  assign unused_par_c = ^PAR_In_DI[MEM_WIDTH-1:DW];

  assign wr_en_c  = WrEn_SI && (Addr_DI == ADDR_WIDTH'(0));
  assign wr_div_c = WrEn_SI && (Addr_DI == ADDR_WIDTH'(1));
  assign wr_clr_c = WrEn_SI && (Addr_DI == ADDR_WIDTH'(2));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_c    = SER_Valid_SI && !valid_q;
  assign push_ok_c = push_c && ((level_q < LW'(FIFO_DEPTH)) || pop_c);

  // Config registers, edge detector and sticky overflow
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      en_q    <= 1'b0;
      div_q   <= DW'(1);
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= SER_Valid_SI;
      if (wr_en_c) en_q <= PAR_In_DI[0];
      if (wr_div_c) div_q <= (PAR_In_DI[DW-1:0] == '0) ? DW'(1) : PAR_In_DI[DW-1:0];
      if (push_c && !push_ok_c) ovf_q <= 1'b1;
      else if (wr_clr_c)        ovf_q <= 1'b0;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by level_q
  always_ff @(posedge Clk_CI) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= SER_In_DI;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + LW'(push_ok_c) - LW'(pop_c);
    end
  end

  // Each bit and the gap last 2*DIV cycles, DIV latched per word
  assign cnt_last_c = (cnt_q == ({wdiv_q, 1'b0} - CW'(1)));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    wdiv_d  = wdiv_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q && (level_q != '0)) begin
          pop_c   = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          bit_d   = BW'(IN_WIDTH - 1);
          cnt_d   = '0;
          wdiv_d  = div_q;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_last_c) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = GAP;
          end else begin
            bit_d   = bit_q - BW'(1);
            shreg_d = {shreg_q[IN_WIDTH-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_last_c) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from next state so they can be registered
    sclk_d  = (state_d == SHIFT) && (cnt_d >= CW'(wdiv_d));
    data_d  = (state_d == SHIFT) && shreg_d[IN_WIDTH-1];
    frame_d = (state_d == SHIFT) && (bit_d == BW'(IN_WIDTH - 1));
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      wdiv_q  <= DW'(1);
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      wdiv_q  <= wdiv_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign SER_Sclk_DO  = sclk_q;
  assign SER_Data_DO  = data_q;
  assign SER_Frame_DO = frame_q;
  assign SER_Busy_DO  = busy_q;
  assign SER_Ovf_DO   = ovf_q;
  assign SER_Level_DO = level_q;

endmodule
